// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage F/D/E/M/W core: tracks register
// tags and write enables through E, M and W, and drives the stall, flush and forward selects.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       regWrite;
    logic       memtoReg;
    logic       pcSrc;
  } eStage_t;

  typedef struct packed {
    logic [3:0] wa3;
    logic       regWrite;
    logic       pcSrc;
  } wbStage_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [3:0] REG_PC  = 4'd15;

  eStage_t          eReg;
  wbStage_t         mReg;
  wbStage_t         wReg;
  logic             validD;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  logic regWriteDq, memtoRegDq, pcSrcDq;
  logic ldStall, pcWrPending;
  logic stallFInt, stallDInt, flushDInt, flushEInt;
  logic [1:0] fwdA, fwdB;

  // M outranks W because it holds the younger of two writers to the same register.
  function automatic logic [1:0] fwdSel(input logic [3:0] ra,
                                        input wbStage_t   m,
                                        input wbStage_t   w);
    if (ra == REG_PC)                    return FWD_RF;
    else if (m.regWrite && m.wa3 == ra)  return FWD_M;
    else if (w.regWrite && w.wa3 == ra)  return FWD_W;
    else                                 return FWD_RF;
  endfunction

  assign regWriteDq  = RegWriteD & validD;
  assign memtoRegDq  = MemtoRegD & validD;
  assign pcSrcDq     = PCSrcD    & validD;

  assign ldStall     = eReg.memtoReg & eReg.regWrite &
                       ((eReg.wa3 == RA1D) | (eReg.wa3 == RA2D));
  assign pcWrPending = pcSrcDq | eReg.pcSrc | mReg.pcSrc;

  assign stallFInt   = ldStall | pcWrPending;
  assign stallDInt   = ldStall;
  assign flushDInt   = pcWrPending | wReg.pcSrc | BranchTakenE;
  assign flushEInt   = ldStall | BranchTakenE;
  assign fwdA        = fwdSel(eReg.ra1, mReg, wReg);
  assign fwdB        = fwdSel(eReg.ra2, mReg, wReg);

  // NOTE: state updates use the ungated hazard terms; the gating below only affects what
  // the datapath sees while RESET is low, when the state is being cleared anyway.
  assign StallF    = RESET & stallFInt;
  assign StallD    = RESET & stallDInt;
  assign FlushD    = RESET & flushDInt;
  assign FlushE    = RESET & flushEInt;
  assign ForwardAE = RESET ? fwdA : FWD_RF;
  assign ForwardBE = RESET ? fwdB : FWD_RF;
  assign StallCnt  = RESET ? stallCnt : '0;
  assign FlushCnt  = RESET ? flushCnt : '0;

  // NOTE: every register here is plain control state, so all of it is cleared by reset;
  // non-blocking assignments let each stage read the previous stage's old value.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      eReg     <= '0;
      mReg     <= '0;
      wReg     <= '0;
      validD   <= 1'b0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (flushEInt) begin
        eReg <= '0;
      end else begin
        eReg <= '{ra1: RA1D, ra2: RA2D, wa3: WA3D, regWrite: regWriteDq,
                  memtoReg: memtoRegDq, pcSrc: pcSrcDq};
      end

      // A condition-failed instruction leaving E loses its write and PC-write effects.
      mReg <= '{wa3: eReg.wa3, regWrite: eReg.regWrite & CondExE,
                pcSrc: eReg.pcSrc & CondExE};
      wReg <= mReg;

      if (flushDInt)       validD <= 1'b0;
      else if (!stallDInt) validD <= 1'b1;

      if (stallDInt && !(&stallCnt)) stallCnt <= stallCnt + CNT_W'(1);
      if (flushEInt && !(&flushCnt)) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

endmodule
